// File: rtl/xtbm_arbiter_if.sv
// Handshake and bus bundle between the requesters, the transfer buffer and the
// xtbm_arbiter. The arbiter connects through the slave modport.
interface xtbm_arbiter_if;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic        rd_err;
    logic        xfer_buf_select;
    logic        mwrite_enable;
    logic [31:0] tbm_address;
    logic        xfer_complete;
    logic [1:0]  xtbm_mode;
    logic        busy;
    logic [7:0]  err_count;

    modport slave (
        input  wr_req, wr_addr, rd_req, rd_addr, xfer_complete,
        output wr_ack, wr_err, rd_ack, rd_err, xfer_buf_select, mwrite_enable,
               tbm_address, xtbm_mode, busy, err_count
    );

    modport master (
        output wr_req, wr_addr, rd_req, rd_addr, xfer_complete,
        input  wr_ack, wr_err, rd_ack, rd_err, xfer_buf_select, mwrite_enable,
               tbm_address, xtbm_mode, busy, err_count
    );
endinterface

// File: rtl/xtbm_arbiter.sv
// Two-requester (write/read) arbiter for the 4KB transfer buffer: alternates on
// contention, watches for a stuck transfer with a timeout, all outputs registered.
module xtbm_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic          clock_fpga,
    input  logic          reset,
    xtbm_arbiter_if.slave bus
);
    localparam logic [1:0] XTBM_NOTHING = 2'd0;
    localparam logic [1:0] XTBM_WRITING = 2'd1;
    localparam logic [1:0] XTBM_READING = 2'd2;
    localparam logic       DIR_READ     = 1'b0;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t      state, state_nx;
    logic        last_dir, last_dir_nx;
    logic [15:0] timer, timer_nx;
    logic        sel_q, sel_nx;
    logic        mw_q, mw_nx;
    logic [31:0] addr_q, addr_nx;
    logic [1:0]  mode_q, mode_nx;
    logic        busy_q, busy_nx;
    logic        wr_ack_q, wr_ack_nx;
    logic        wr_err_q, wr_err_nx;
    logic        rd_ack_q, rd_ack_nx;
    logic        rd_err_q, rd_err_nx;
    logic [7:0]  err_cnt_q, err_cnt_nx;

    logic timeout_hit;
    logic timed_out;
    logic grant_wr;
    logic grant_rd;

    // On contention the write side wins only if the previous grant was a read.
    always_comb begin
        timeout_hit = (TIMEOUT != 16'd0) && (timer == TIMEOUT - 16'd1);
        timed_out   = timeout_hit && !bus.xfer_complete;
        grant_wr    = bus.wr_req && (!bus.rd_req || last_dir == DIR_READ);
        grant_rd    = bus.rd_req && !grant_wr;
    end

    always_comb begin
        state_nx    = state;
        last_dir_nx = last_dir;
        timer_nx    = timer;
        sel_nx      = sel_q;
        mw_nx       = mw_q;
        addr_nx     = addr_q;
        mode_nx     = mode_q;
        wr_ack_nx   = 1'b0;
        wr_err_nx   = 1'b0;
        rd_ack_nx   = 1'b0;
        rd_err_nx   = 1'b0;
        err_cnt_nx  = err_cnt_q;

        case (state)
            IDLE: begin
                if (grant_wr || grant_rd) begin
                    state_nx    = XFER;
                    last_dir_nx = grant_wr;
                    timer_nx    = 16'd0;
                    sel_nx      = 1'b1;
                    mw_nx       = grant_wr;
                    addr_nx     = grant_wr ? bus.wr_addr : bus.rd_addr;
                    mode_nx     = grant_wr ? XTBM_WRITING : XTBM_READING;
                end
            end
            XFER: begin
                timer_nx = timer + 16'd1;
                if (bus.xfer_complete || timeout_hit) begin
                    state_nx  = GAP;
                    sel_nx    = 1'b0;
                    mw_nx     = 1'b0;
                    mode_nx   = XTBM_NOTHING;
                    wr_ack_nx = mw_q;
                    rd_ack_nx = !mw_q;
                    wr_err_nx = mw_q && timed_out;
                    rd_err_nx = !mw_q && timed_out;
                    if (timed_out && err_cnt_q != 8'hFF)
                        err_cnt_nx = err_cnt_q + 8'd1;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_dir  <= DIR_READ;
            timer     <= 16'd0;
            sel_q     <= 1'b0;
            mw_q      <= 1'b0;
            addr_q    <= 32'd0;
            mode_q    <= XTBM_NOTHING;
            busy_q    <= 1'b0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state     <= state_nx;
            last_dir  <= last_dir_nx;
            timer     <= timer_nx;
            sel_q     <= sel_nx;
            mw_q      <= mw_nx;
            addr_q    <= addr_nx;
            mode_q    <= mode_nx;
            busy_q    <= busy_nx;
            wr_ack_q  <= wr_ack_nx;
            wr_err_q  <= wr_err_nx;
            rd_ack_q  <= rd_ack_nx;
            rd_err_q  <= rd_err_nx;
            err_cnt_q <= err_cnt_nx;
        end
    end

    assign bus.xfer_buf_select = sel_q;
    assign bus.mwrite_enable   = mw_q;
    assign bus.tbm_address     = addr_q;
    assign bus.xtbm_mode       = mode_q;
    assign bus.busy            = busy_q;
    assign bus.wr_ack          = wr_ack_q;
    assign bus.wr_err          = wr_err_q;
    assign bus.rd_ack          = rd_ack_q;
    assign bus.rd_err          = rd_err_q;
    assign bus.err_count       = err_cnt_q;
endmodule

// File: doc/xtbm_arbiter.md
XTBM_ARBITER -- requirements
Module: xtbm_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16'd1024, cycles allowed between grant and xfer_complete; 0 disables the timeout.
REQ-002 clock_fpga  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock_fpga.
REQ-004 wr_req  input  1  write requester (host -> TBM) wants one 4KB transfer.
REQ-005 wr_addr  input  32  TBM address for the write transfer.
REQ-006 wr_ack  output  1  one-cycle pulse when the write transfer ends.
REQ-007 wr_err  output  1  qualifies wr_ack: the transfer ended by timeout.
REQ-008 rd_req  input  1  read requester (TBM -> host) wants one 4KB transfer.
REQ-009 rd_addr  input  32  TBM address for the read transfer.
REQ-010 rd_ack  output  1  one-cycle pulse when the read transfer ends.
REQ-011 rd_err  output  1  qualifies rd_ack: the transfer ended by timeout.
REQ-012 xfer_buf_select  output  1  transfer-buffer enable, high for the whole granted transfer.
REQ-013 mwrite_enable  output  1  1 = write direction, 0 = read direction; valid while xfer_buf_select is high, else 0.
REQ-014 tbm_address  output  32  latched address of the granted transfer.
REQ-015 xfer_complete  input  1  transfer buffer reports that the current 4KB transfer is finished.
REQ-016 xtbm_mode  output  2  XTBM_NOTHING / XTBM_WRITING / XTBM_READING codes from hd_parameter.vh.
REQ-017 busy  output  1  high when the state is not IDLE.
REQ-018 err_count  output  8  number of timeouts since reset, saturating.

Function
REQ-019 The FSM SHALL have states IDLE, XFER and GAP, with every output registered.
REQ-020 In IDLE with exactly one request sampled high, the arbiter SHALL grant that requester.
REQ-021 In IDLE with both requests high, the arbiter SHALL grant the direction opposite to last_dir.
- last_dir is an internal bit; reset value is READ, so the first contested grant goes to WRITE.
REQ-022 On a grant at edge k, the following SHALL all happen after edge k:
- xfer_buf_select = 1.
- mwrite_enable = 1 for a write, 0 for a read.
- tbm_address = the granted requester's address, sampled at edge k.
- xtbm_mode = WRITING or READING.
- last_dir updated; state = XFER; timer = 0.
REQ-023 In XFER, the timer SHALL increment each cycle; a 16-bit timer is sufficient.
REQ-024 In XFER, xfer_complete sampled high at edge m SHALL cause the following after edge m:
- xfer_buf_select, mwrite_enable and xtbm_mode cleared (xtbm_mode = NOTHING).
- granted ack = 1, err = 0.
- state = GAP.
REQ-025 In XFER with TIMEOUT != 0, timer == TIMEOUT-1 without xfer_complete SHALL end the transfer as in REQ-024, except:
- err = 1 together with ack.
- err_count incremented, saturating at 255.
REQ-026 If xfer_complete and the timeout condition occur on the same edge, xfer_complete SHALL win (no error).
REQ-027 In GAP, ack/err SHALL clear after the next edge and the state SHALL return to IDLE.
- xfer_buf_select is therefore low for at least 2 cycles between transfers.
- The earliest next grant is edge m+2.
REQ-028 A request dropped during XFER SHALL not abort the transfer; completion and ack proceed normally.
REQ-029 The arbiter SHALL sample requests only in IDLE.
- A requester holding req high through its own ack cycle is re-arbitrated in IDLE.
REQ-030 xfer_complete SHALL be ignored in IDLE and GAP.
REQ-031 tbm_address SHALL hold its last value when idle.
REQ-032 wr_ack and rd_ack SHALL never be high together; each err output SHALL be high only together with its own ack.

Reset
REQ-033 While reset is high, the block SHALL hold:
- state IDLE, last_dir READ, timer 0, err_count 0.
- all 1-bit outputs 0, tbm_address 0, xtbm_mode XTBM_NOTHING.
REQ-034 Reset asserted mid-XFER SHALL drop xfer_buf_select asynchronously and generate no ack.
- After reset releases, arbitration restarts from IDLE.

Verification
REQ-035 Single write:
- Stimulus: wr_req=1, wr_addr=32'h0000_1000; xfer_complete pulsed 5 cycles after the grant.
- Response: select=1, mwrite_enable=1, tbm_address=32'h1000, xtbm_mode=WRITING for 5 cycles, then a one-cycle wr_ack with wr_err=0.
REQ-036 Contention after reset:
- Stimulus: wr_req and rd_req held high together.
- Response: write granted first, then read, then write, alternating; select low at least 2 cycles between grants.
REQ-037 Timeout:
- Stimulus: TIMEOUT=16, rd_req=1, no xfer_complete.
- Response: select drops 16 cycles after the grant; rd_ack=1 and rd_err=1 together; err_count=1.
REQ-038 Simultaneous events:
- Stimulus: TIMEOUT=8, xfer_complete on the timeout cycle.
- Response: ack with err=0; err_count unchanged.
REQ-039 Reset mid-transfer:
- Stimulus: reset pulsed 3 cycles into a read.
- Response: select=0 immediately, no rd_ack, xtbm_mode=NOTHING; a contested request afterwards grants write.
REQ-040 Spurious and dropped signals:
- Stimulus: xfer_complete pulsed in IDLE; also wr_req dropped mid-XFER.
- Response: the spurious pulse causes no state change; the dropped-request transfer completes and still issues wr_ack.
